// File: rtl/sr_bank_driver.sv
// Write-side sequencer for a bank of SR flip-flops: pulse s/r, settle, read back, retry.
// Define SR_BANK_DRIVER_TOGGLE_EN to drive changing bits with the s=r=1 toggle code.
//
// state  | meaning
// IDLE   | waiting for a target word, in_ready high
// DRIVE  | one-cycle s/r excitation pulse on the bank
// SETTLE | SETTLE_CYC quiet cycles while the bank settles
// VERIFY | compare bank readback to target; finish, retry or give up

module sr_bank_driver #(
   parameter int WIDTH      = 8,
   parameter int SETTLE_CYC = 2,
   parameter int MAX_RETRY  = 3,
   parameter int RC_W       = 2
) (
   input  logic             cp,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] s_out,
   output logic [WIDTH-1:0] r_out,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [RC_W-1:0]  retry_cnt,
   output logic [7:0]       err_cnt
);

   typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_SETTLE, ST_VERIFY} state_t;

   localparam int              SC_W         = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SC_W-1:0] LP_SETTLE_LD = SC_W'(SETTLE_CYC - 1);
   localparam logic [RC_W-1:0] LP_MAX_RETRY = RC_W'(MAX_RETRY);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [SC_W-1:0]  r_settle_cnt;
   logic [WIDTH-1:0] r_target;
   logic [WIDTH-1:0] w_tgt;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_s;
   logic [WIDTH-1:0] w_r;
   logic             w_accept;
   logic             w_match;
   logic             w_settle_tc;
   logic             w_retry_ok;

   assign in_ready    = (r_state == ST_IDLE);
   assign busy        = ~in_ready;
   assign w_accept    = in_valid & in_ready;
   assign w_match     = (q_in == r_target);
   assign w_settle_tc = (r_settle_cnt == '0);
   assign w_retry_ok  = (retry_cnt < LP_MAX_RETRY);

   // Excitation is computed from in_data on accept and from the latched target on retries.
   assign w_tgt  = (r_state == ST_IDLE) ? in_data : r_target;
   assign w_diff = w_tgt ^ q_in;

`ifdef SR_BANK_DRIVER_TOGGLE_EN
   assign w_s = w_diff;
   assign w_r = w_diff;
`else
   assign w_s = w_tgt & ~q_in;
   assign w_r = ~w_tgt & q_in;
`endif

   always_ff @(posedge cp) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_accept) w_state_nxt = ST_DRIVE;
         ST_DRIVE:  w_state_nxt = ST_SETTLE;
         ST_SETTLE: if (w_settle_tc) w_state_nxt = ST_VERIFY;
         ST_VERIFY: begin
            if (w_match)         w_state_nxt = ST_IDLE;
            else if (w_retry_ok) w_state_nxt = ST_DRIVE;
            else                 w_state_nxt = ST_IDLE;
         end
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge cp) begin
      if (rst) begin
         s_out        <= '0;
         r_out        <= '0;
         done         <= 1'b0;
         err          <= 1'b0;
         retry_cnt    <= '0;
         err_cnt      <= '0;
         r_target     <= '0;
         r_settle_cnt <= '0;
      end else begin
         s_out <= '0;
         r_out <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_target  <= in_data;
                  retry_cnt <= '0;
                  s_out     <= w_s;
                  r_out     <= w_r;
               end
            end
            ST_DRIVE:  r_settle_cnt <= LP_SETTLE_LD;
            ST_SETTLE: if (!w_settle_tc) r_settle_cnt <= r_settle_cnt - 1'b1;
            ST_VERIFY: begin
               if (w_match) begin
                  done <= 1'b1;
               end else if (w_retry_ok) begin
                  retry_cnt <= retry_cnt + 1'b1;
                  s_out     <= w_s;
                  r_out     <= w_r;
               end else begin
                  err <= 1'b1;
                  if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sr_bank_driver.sv
// Scoreboard bench for sr_bank_driver: an SR bank model with stuck-at-0 bits feeds q_in,
// a transaction-level reference predicts pulses, outcome, latency and counters.

module tb_sr_bank_driver;

   localparam int WIDTH = 8;
   localparam int SC    = 2;
   localparam int MR    = 3;
   localparam int PER   = SC + 2;

   logic             cp = 1'b0;
   logic             rst, in_valid, in_ready, busy, done, err;
   logic [WIDTH-1:0] in_data, q_in, s_out, r_out;
   logic [1:0]       retry_cnt;
   logic [7:0]       err_cnt;

   always #5 cp = ~cp;

   sr_bank_driver #(.WIDTH(WIDTH), .SETTLE_CYC(SC), .MAX_RETRY(MR), .RC_W(2)) dut (
      .cp(cp), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .q_in(q_in), .s_out(s_out), .r_out(r_out), .busy(busy), .done(done), .err(err),
      .retry_cnt(retry_cnt), .err_cnt(err_cnt));

   logic [7:0] bank_q = 8'h00;
   logic [7:0] stuck, ld_val;
   logic       ld_en;

   function automatic logic [7:0] sr_next(input logic [7:0] q, input logic [7:0] s, input logic [7:0] r);
      return (s & ~r) | (q & ~s & ~r) | (~q & s & r);
   endfunction

   always @(posedge cp) bank_q <= (ld_en ? ld_val : sr_next(bank_q, s_out, r_out)) & ~stuck;
   assign q_in = bank_q;

   typedef struct {
      logic       fail;
      logic [1:0] retries;
      logic [7:0] errs;
      int         lat;
      int         n;
      logic [7:0] s[4];
      logic [7:0] r[4];
      int         off[4];
      int         acc;
      logic [7:0] tgt;
   } exp_t;

   exp_t sbq[$];
   exp_t e_push, e_chk;
   int   cyc = 0;
   logic rst_seen = 1'b1;
   int   n_chk = 0, n_fail = 0, b2b = 0, nlog = 0;
   int   exp_errs = 0;
   logic [7:0] log_s[8], log_r[8];
   int   log_c[8];

   always @(posedge cp) begin
      cyc      <= cyc + 1;
      rst_seen <= rst;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference: every drive leaves the bank at target minus stuck bits; success needs no stuck 1s.
   always @(negedge cp) begin
      if (rst_seen) begin
         sbq.delete();
         exp_errs = 0;
      end
      if (!rst && in_valid && in_ready) begin
         logic [7:0] t, q, s, r;
         int na;
         t = in_data;
         q = q_in;
         e_push.fail = (t & stuck) != 8'h00;
         na = e_push.fail ? MR + 1 : 1;
         e_push.n = 0;
         for (int a = 0; a < na; a++) begin
`ifdef SR_BANK_DRIVER_TOGGLE_EN
            s = t ^ q;
            r = t ^ q;
`else
            s = t & ~q;
            r = ~t & q;
`endif
            if ((s | r) != 8'h00) begin
               e_push.s[e_push.n]   = s;
               e_push.r[e_push.n]   = r;
               e_push.off[e_push.n] = a * PER;
               e_push.n++;
            end
            q = t & ~stuck;
         end
         if (e_push.fail) exp_errs = (exp_errs >= 255) ? 255 : exp_errs + 1;
         e_push.retries = 2'(na - 1);
         e_push.errs    = 8'(exp_errs);
         e_push.lat     = na * PER;
         e_push.acc     = cyc + 1;
         e_push.tgt     = t;
         if (done) b2b++;
         sbq.push_back(e_push);
      end
   end

   always @(negedge cp) begin
      if (rst_seen) begin
         nlog = 0;
         chk("rst_busy", busy, 0);
         chk("rst_s_out", s_out, 0);
         chk("rst_r_out", r_out, 0);
         chk("rst_done", done, 0);
         chk("rst_err", err, 0);
         chk("rst_err_cnt", err_cnt, 0);
         chk("rst_retry_cnt", retry_cnt, 0);
      end else begin
         chk("busy_vs_ready", busy, !in_ready);
         if ((s_out | r_out) != 8'h00) begin
`ifndef SR_BANK_DRIVER_TOGGLE_EN
            chk("no_toggle_code", s_out & r_out, 0);
`endif
            if (nlog < 8) begin
               log_s[nlog] = s_out;
               log_r[nlog] = r_out;
               log_c[nlog] = cyc;
            end
            nlog++;
         end
         if (done || err) begin
            if (sbq.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_result: done=%0b err=%0b with no pending request", done, err);
            end else begin
               e_chk = sbq.pop_front();
               chk("result_err", err, e_chk.fail);
               chk("result_done", done, !e_chk.fail);
               chk("retry_cnt", retry_cnt, e_chk.retries);
               chk("err_cnt", err_cnt, e_chk.errs);
               chk("latency_edges", cyc - e_chk.acc, e_chk.lat);
               chk("ready_at_result", in_ready, 1);
               chk("drive_pulses", nlog, e_chk.n);
               for (int i = 0; i < e_chk.n && i < nlog && i < 4; i++) begin
                  chk("drive_s", log_s[i], e_chk.s[i]);
                  chk("drive_r", log_r[i], e_chk.r[i]);
                  chk("drive_offset", log_c[i] - e_chk.acc, e_chk.off[i]);
               end
               if (!e_chk.fail) chk("bank_final", bank_q, e_chk.tgt);
            end
            nlog = 0;
         end
      end
   end

   task automatic load(input logic [7:0] v);
      ld_val = v;
      ld_en  = 1'b1;
      @(posedge cp); #1;
      ld_en  = 1'b0;
   endtask

   task automatic send(input logic [7:0] d);
      int b = 0;
      in_valid = 1'b1;
      in_data  = d;
      do begin
         @(negedge cp); #1;
         b++;
      end while (!(in_ready && !rst) && b < 200);
      if (b >= 200) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready=%0b expected 1 within 200 cycles", in_ready);
      end
      @(posedge cp); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int b = 0;
      do begin
         @(negedge cp); #1;
         b++;
      end while ((sbq.size() != 0 || !in_ready) && b < 200);
      if (b >= 200) begin
         n_chk++;
         n_fail++;
         $display("FAIL idle_timeout: pending=%0d expected 0 within 200 cycles", sbq.size());
      end
      @(posedge cp); #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
      ld_en = 1'b0; ld_val = 8'h00; stuck = 8'h00;
      repeat (2) @(posedge cp);
      #1 rst = 1'b0;

      load(8'h00); send(8'hA5); wait_idle();
      load(8'hF0); send(8'h3C); wait_idle();

      stuck = 8'h01;
      load(8'h00); send(8'h01); wait_idle();
      stuck = 8'h00;

      load(8'h5A); send(8'h5A); send(8'hC3); wait_idle();
      chk("back_to_back_accept", b2b, 1);

      // Reset lands in SETTLE while a new request is already offered.
      load(8'h00); send(8'h0F);
      @(posedge cp); #1;
      rst = 1'b1; in_valid = 1'b1; in_data = 8'h77;
      @(posedge cp); #1;
      rst = 1'b0;
      send(8'h77); wait_idle();

      load(8'h0F); send(8'hF0); wait_idle();

      for (int i = 0; i < 40; i++) begin
         stuck = ($urandom_range(0, 3) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
         load(8'($urandom));
         repeat ($urandom_range(0, 2)) @(posedge cp);
         #1;
         send(8'($urandom));
         wait_idle();
      end

      // Push the failure counter past its saturation point.
      stuck = 8'h01;
      load(8'h00);
      for (int i = 0; i < 258; i++) send(8'h01);
      wait_idle();
      stuck = 8'h00;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
